top_mult: RTL and testbench

- Keypad-driven 4-digit × 4-digit decimal multiplier with seven-segment outputs. This is the top-level block.
- A 3×4 telephone keypad is wired directly to the pins. A "set" button steps through entry of operand A (multiplicand), entry of operand B (multiplier), and computation.
- A and B are shown on two 4-digit groups. The 8-digit decimal product is shown on a third group and is computed with a radix-4 Booth multiplier.

---
 rtl/top_mult.sv | 225 ++++++++++++++++++++++
 tb/tb_top_mult.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/top_mult.sv
// Keypad-driven 4x4 digit decimal multiplier: debounced keypad entry of two BCD
// operands, radix-4 Booth multiply, and eight-digit seven-segment product display.
module top_mult #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       skp_c1,
  input  logic       skp_c2,
  input  logic       skp_c3,
  input  logic       skp_r1,
  input  logic       skp_r2,
  input  logic       skp_r3,
  input  logic       skp_r4,
  output logic [7:0] seg_7_00,
  output logic [7:0] seg_7_01,
  output logic [7:0] seg_7_02,
  output logic [7:0] seg_7_03,
  output logic [7:0] seg_7_10,
  output logic [7:0] seg_7_11,
  output logic [7:0] seg_7_12,
  output logic [7:0] seg_7_13,
  output logic [7:0] seg_7_o0,
  output logic [7:0] seg_7_o1,
  output logic [7:0] seg_7_o2,
  output logic [7:0] seg_7_o3,
  output logic [7:0] seg_7_o4,
  output logic [7:0] seg_7_o5,
  output logic [7:0] seg_7_o6,
  output logic [7:0] seg_7_o7
);

  typedef enum logic [2:0] {IDLE, ENTER_A, ENTER_B, CALC, SHOW} state_t;
  localparam int CW = $clog2(DEBOUNCE + 1);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd1:    return 8'b01100000;
      4'd2:    return 8'b11011010;
      4'd3:    return 8'b11110010;
      4'd4:    return 8'b01100110;
      4'd5:    return 8'b10110110;
      4'd6:    return 8'b10111110;
      4'd7:    return 8'b11100000;
      4'd8:    return 8'b11111110;
      4'd9:    return 8'b11110110;
      default: return 8'b11111100;
    endcase
  endfunction

  function automatic logic [13:0] bcd2bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100 +
           14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

  function automatic logic [31:0] bin2bcd(input logic [31:0] bin);
    logic [63:0] sh;
    sh = {32'd0, bin};
    for (int unsigned i = 0; i < 32; i++) begin
      for (int unsigned d = 0; d < 8; d++) begin
        if (sh[32+4*d +: 4] > 4'd4) sh[32+4*d +: 4] = sh[32+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[63:32];
  endfunction

  // Synchronizer bit order: {set, r4, r3, r2, r1, c3, c2, c1}
  logic [7:0] r_sync1, r_sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {set, skp_r4, skp_r3, skp_r2, skp_r1, skp_c3, skp_c2, skp_c1};
      r_sync2 <= r_sync1;
    end
  end

  logic [2:0] w_cols;
  logic [3:0] w_rows;
  logic [3:0] w_col;
  logic [4:0] w_code;  // {valid, digit}
  assign w_cols = ~r_sync2[2:0];
  assign w_rows = ~r_sync2[6:3];

  always_comb begin
    w_code = '0;
    w_col  = 4'd3;
    if (w_cols == 3'b001) w_col = 4'd1;
    else if (w_cols == 3'b010) w_col = 4'd2;
    if ($onehot(w_cols) && $onehot(w_rows)) begin
      case (w_rows)
        4'b0001: w_code = {1'b1, w_col};
        4'b0010: w_code = {1'b1, w_col + 4'd3};
        4'b0100: w_code = {1'b1, w_col + 4'd6};
        4'b1000: if (w_col == 4'd2) w_code = 5'b1_0000;
        default: w_code = '0;
      endcase
    end
  end

  // A digit fires once when stable; re-armed only after a stable release.
  logic [4:0]    r_code;
  logic [CW-1:0] r_cnt;
  logic          r_armed, r_set_d;
  logic          w_stable, w_accept, w_set_evt;
  assign w_stable  = (r_cnt == CW'(DEBOUNCE));
  assign w_accept  = w_stable && r_code[4] && r_armed;
  assign w_set_evt = r_sync2[7] && !r_set_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code  <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_set_d <= 1'b0;
    end else begin
      r_set_d <= r_sync2[7];
      if (w_code != r_code) begin
        r_code <= w_code;
        r_cnt  <= CW'(1);
      end else if (!w_stable) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) r_armed <= 1'b0;
      else if (w_stable && !r_code[4]) r_armed <= 1'b1;
    end
  end

  state_t r_state, w_state_next;
  logic [2:0] r_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_set_evt) w_state_next = ENTER_A;
      ENTER_A: if (w_set_evt) w_state_next = ENTER_B;
      ENTER_B: if (w_set_evt) w_state_next = CALC;
      CALC:    if (r_iter == 3'd7) w_state_next = SHOW;
      SHOW:    if (w_set_evt) w_state_next = ENTER_A;
      default: w_state_next = IDLE;
    endcase
  end

  logic [15:0] r_a, r_b, w_a_next, w_b_next;
  logic [31:0] r_prod, r_acc, r_msh, w_pp, w_acc_next, w_prod_bcd;
  logic [18:0] r_mplr;
  logic [17:0] w_m18, w_q18;

  // Booth operands come from the post-key value of B so a key and set landing together count.
  assign w_a_next   = (r_state == ENTER_A && w_accept) ? {r_a[11:0], r_code[3:0]} : r_a;
  assign w_b_next   = (r_state == ENTER_B && w_accept) ? {r_b[11:0], r_code[3:0]} : r_b;
  assign w_m18      = {4'd0, bcd2bin(r_a)};
  assign w_q18      = {4'd0, bcd2bin(w_b_next)};
  assign w_acc_next = r_acc + w_pp;
  assign w_prod_bcd = bin2bcd(w_acc_next);

  always_comb begin
    case (r_mplr[2:0])
      3'b001, 3'b010: w_pp = r_msh;
      3'b011:         w_pp = r_msh << 1;
      3'b100:         w_pp = -(r_msh << 1);
      3'b101, 3'b110: w_pp = -r_msh;
      default:        w_pp = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_msh  <= '0;
      r_mplr <= '0;
      r_iter <= '0;
    end else begin
      if (w_set_evt && (r_state == IDLE || r_state == SHOW)) begin
        r_a    <= '0;
        r_b    <= '0;
        r_prod <= '0;
      end else begin
        r_a <= w_a_next;
        r_b <= w_b_next;
      end
      if (r_state == ENTER_B && w_set_evt) begin
        r_acc  <= '0;
        r_msh  <= {{14{w_m18[17]}}, w_m18};
        r_mplr <= {w_q18, 1'b0};
        r_iter <= '0;
      end else if (r_state == CALC) begin
        r_acc  <= w_acc_next;
        r_msh  <= r_msh << 2;
        r_mplr <= {2'b00, r_mplr[18:2]};
        r_iter <= r_iter + 3'd1;
        if (r_iter == 3'd7) r_prod <= w_prod_bcd;
      end
    end
  end

  assign seg_7_00 = seg7(r_a[3:0]);
  assign seg_7_01 = seg7(r_a[7:4]);
  assign seg_7_02 = seg7(r_a[11:8]);
  assign seg_7_03 = seg7(r_a[15:12]);
  assign seg_7_10 = seg7(r_b[3:0]);
  assign seg_7_11 = seg7(r_b[7:4]);
  assign seg_7_12 = seg7(r_b[11:8]);
  assign seg_7_13 = seg7(r_b[15:12]);
  assign seg_7_o0 = seg7(r_prod[3:0]);
  assign seg_7_o1 = seg7(r_prod[7:4]);
  assign seg_7_o2 = seg7(r_prod[11:8]);
  assign seg_7_o3 = seg7(r_prod[15:12]);
  assign seg_7_o4 = seg7(r_prod[19:16]);
  assign seg_7_o5 = seg7(r_prod[23:20]);
  assign seg_7_o6 = seg7(r_prod[27:24]);
  assign seg_7_o7 = seg7(r_prod[31:28]);

endmodule

// File: tb/tb_top_mult.sv
// Directed bench for top_mult: table of operand/product vectors plus
// hand-written sequences for debounce, latency and reset-during-CALC.
module tb_top_mult;

  logic clk = 1'b0;
  logic rst, set;
  logic skp_c1, skp_c2, skp_c3, skp_r1, skp_r2, skp_r3, skp_r4;
  logic [7:0] seg_7_00, seg_7_01, seg_7_02, seg_7_03;
  logic [7:0] seg_7_10, seg_7_11, seg_7_12, seg_7_13;
  logic [7:0] seg_7_o0, seg_7_o1, seg_7_o2, seg_7_o3;
  logic [7:0] seg_7_o4, seg_7_o5, seg_7_o6, seg_7_o7;

  top_mult #(.DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .set(set),
    .skp_c1(skp_c1), .skp_c2(skp_c2), .skp_c3(skp_c3),
    .skp_r1(skp_r1), .skp_r2(skp_r2), .skp_r3(skp_r3), .skp_r4(skp_r4),
    .seg_7_00(seg_7_00), .seg_7_01(seg_7_01), .seg_7_02(seg_7_02), .seg_7_03(seg_7_03),
    .seg_7_10(seg_7_10), .seg_7_11(seg_7_11), .seg_7_12(seg_7_12), .seg_7_13(seg_7_13),
    .seg_7_o0(seg_7_o0), .seg_7_o1(seg_7_o1), .seg_7_o2(seg_7_o2), .seg_7_o3(seg_7_o3),
    .seg_7_o4(seg_7_o4), .seg_7_o5(seg_7_o5), .seg_7_o6(seg_7_o6), .seg_7_o7(seg_7_o7)
  );

  always #5 clk = ~clk;

  logic [31:0] w_a_disp, w_b_disp;
  logic [63:0] w_p_disp;
  assign w_a_disp = {seg_7_03, seg_7_02, seg_7_01, seg_7_00};
  assign w_b_disp = {seg_7_13, seg_7_12, seg_7_11, seg_7_10};
  assign w_p_disp = {seg_7_o7, seg_7_o6, seg_7_o5, seg_7_o4,
                     seg_7_o3, seg_7_o2, seg_7_o1, seg_7_o0};

  logic [7:0] seg_tab [10] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
                               8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
                               8'b11111110, 8'b11110110};

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  typedef struct {
    int unsigned na;
    int unsigned ka[5];
    int unsigned nb;
    int unsigned kb[4];
    int unsigned ea;
    int unsigned eb;
    int unsigned ep;
  } vec_t;

  function automatic logic [63:0] exp_disp(input int unsigned v, input int unsigned ndig);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < ndig; i++) begin
      r[8*i +: 8] = seg_tab[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int unsigned a, input int unsigned b,
                           input int unsigned p);
    check({tag, " A"}, {32'd0, w_a_disp}, exp_disp(a, 4));
    check({tag, " B"}, {32'd0, w_b_disp}, exp_disp(b, 4));
    check({tag, " P"}, w_p_disp, exp_disp(p, 8));
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_key(input int unsigned d);
    {skp_c1, skp_c2, skp_c3, skp_r1, skp_r2, skp_r3, skp_r4} = '1;
    if (d == 0) begin
      skp_r4 = 1'b0; skp_c2 = 1'b0;
    end else if (d == 10) begin
      skp_r4 = 1'b0; skp_c1 = 1'b0;       // row4/c1: not a key
    end else if (d <= 9) begin
      case ((d - 1) / 3)
        0: skp_r1 = 1'b0;
        1: skp_r2 = 1'b0;
        default: skp_r3 = 1'b0;
      endcase
      case ((d - 1) % 3)
        0: skp_c1 = 1'b0;
        1: skp_c2 = 1'b0;
        default: skp_c3 = 1'b0;
      endcase
    end
  endtask

  task automatic press(input int unsigned d, input int unsigned hold);
    @(negedge clk);
    drive_key(d);
    tick(hold);
    drive_key(99);
    tick(10);
  endtask

  task automatic pulse_set();
    @(negedge clk);
    set = 1'b1;
    tick(6);
    set = 1'b0;
    tick(6);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    pulse_set();
    for (int unsigned i = 0; i < v.na; i++) press(v.ka[i], 10);
    pulse_set();
    for (int unsigned i = 0; i < v.nb; i++) press(v.kb[i], 10);
    pulse_set();
    tick(30);
    check_all(tag, v.ea, v.eb, v.ep);
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{5, '{4,4,7,2,5}, 3, '{1,3,6,0}, 4725, 136, 642600};
    vt[1] = '{4, '{9,9,9,9,0}, 4, '{9,9,9,9}, 9999, 9999, 99980001};
    vt[2] = '{4, '{1,2,3,4,0}, 0, '{0,0,0,0}, 1234, 0, 0};
    vt[3] = '{2, '{1,2,0,0,0}, 2, '{3,4,0,0}, 12, 34, 408};
    vt[4] = '{5, '{9,8,7,6,5}, 4, '{4,3,2,1}, 8765, 4321, 37873565};
    vt[5] = '{4, '{1,0,0,0,0}, 4, '{1,0,0,0}, 1000, 1000, 1000000};
    vt[6] = '{4, '{0,0,0,7,0}, 1, '{8,0,0,0}, 7, 8, 56};
    vt[7] = '{4, '{2,5,0,0,0}, 3, '{3,9,9,0}, 2500, 399, 997500};
    vt[8] = '{4, '{6,7,8,9,0}, 4, '{9,8,7,6}, 6789, 9876, 67048164};
    vt[9] = '{1, '{1,0,0,0,0}, 1, '{1,0,0,0}, 1, 1, 1};

    rst = 1'b1;
    set = 1'b0;
    drive_key(99);
    tick(3);
    rst = 1'b0;
    tick(3);
    check_all("reset", 0, 0, 0);

    press(5, 10);
    check_all("key in IDLE", 0, 0, 0);

    for (int unsigned i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    for (int unsigned r = 0; r < 4; r++) begin
      vec_t v;
      int unsigned a, b;
      a = $urandom_range(0, 99999);
      b = $urandom_range(0, 999);
      v.na = 5;
      v.nb = 3;
      v.ka = '{(a / 10000) % 10, (a / 1000) % 10, (a / 100) % 10, (a / 10) % 10, a % 10};
      v.kb = '{(b / 100) % 10, (b / 10) % 10, b % 10, 0};
      v.ea = a % 10000;
      v.eb = b;
      v.ep = (a % 10000) * b;
      run_vec(v, $sformatf("rand%0d", r));
    end

    pulse_set();
    press(3, 50);
    check("held key", {32'd0, w_a_disp}, exp_disp(3, 4));
    @(negedge clk);
    drive_key(7);
    tick(2);
    drive_key(99);
    tick(10);
    check("glitch", {32'd0, w_a_disp}, exp_disp(3, 4));
    press(10, 10);
    check("row4 c1", {32'd0, w_a_disp}, exp_disp(3, 4));
    press(0, 10);
    check("key 0", {32'd0, w_a_disp}, exp_disp(30, 4));
    pulse_set();
    press(2, 10);
    check("B entry", {32'd0, w_b_disp}, exp_disp(2, 4));
    check("P cleared", w_p_disp, exp_disp(0, 8));
    @(negedge clk);
    set = 1'b1;
    tick(12);
    check("latency", w_p_disp, exp_disp(60, 8));
    set = 1'b0;
    tick(6);

    pulse_set();
    press(1, 10);
    press(2, 10);
    pulse_set();
    press(3, 10);
    press(4, 10);
    @(negedge clk);
    set = 1'b1;
    tick(5);
    #1 rst = 1'b1;
    set = 1'b0;
    #1 check_all("rst in CALC", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(6);
    check_all("after CALC rst", 0, 0, 0);
    press(5, 10);
    check("IDLE after rst", {32'd0, w_a_disp}, exp_disp(0, 4));
    pulse_set();
    press(5, 10);
    check("entry after rst", {32'd0, w_a_disp}, exp_disp(5, 4));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
